// File: rtl/v810_bus_arb.sv
// v810_bus_arb: shares the V810 external bus between the CPU bus controller and one
// secondary master (DMA). The CPU owns the bus by default. The DMA master gets the bus via
// the HLDRQn/HLDAKn hold handshake, keeps it for at most MAX_HOLD CE cycles, and gives it
// back only at a bus-cycle boundary.
//
// Ports:
//   CLK, RES, CE                       clock, synchronous active-high reset, clock enable
//   CPU_* (A, DO, BEn, strobes)        CPU master request side
//   CPU_DI, CPU_READYn, CPU_SZRQn      responses to CPU (READYn/SZRQn only when CPU owns)
//   CPU_HLDRQn / CPU_HLDAKn            hold request to / acknowledge from the CPU
//   DMA_REQ / DMA_GNT                  DMA bus request (level) / grant
//   DMA_* (A, DO, BEn, strobes)        DMA master request side
//   DMA_DI, DMA_READYn, DMA_SZRQn      responses to DMA (READYn/SZRQn only when DMA owns)
//   A, D_O, BEn, DAn, MRQn, RW, BCYSTn muxed external bus
//   D_I, READYn, SZRQn                 external bus responses
//   OWNER                              0 = CPU drives the bus, 1 = DMA drives the bus
module v810_bus_arb #(
    parameter int unsigned MAX_HOLD = 64,
    parameter int unsigned REARM    = 4
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic [31:0] CPU_A,
    input  logic [31:0] CPU_DO,
    input  logic [3:0]  CPU_BEn,
    input  logic        CPU_DAn,
    input  logic        CPU_MRQn,
    input  logic        CPU_RW,
    input  logic        CPU_BCYSTn,
    output logic [31:0] CPU_DI,
    output logic        CPU_READYn,
    output logic        CPU_SZRQn,
    output logic        CPU_HLDRQn,
    input  logic        CPU_HLDAKn,
    input  logic        DMA_REQ,
    output logic        DMA_GNT,
    input  logic [31:0] DMA_A,
    input  logic [31:0] DMA_DO,
    input  logic [3:0]  DMA_BEn,
    input  logic        DMA_DAn,
    input  logic        DMA_MRQn,
    input  logic        DMA_RW,
    input  logic        DMA_BCYSTn,
    output logic [31:0] DMA_DI,
    output logic        DMA_READYn,
    output logic        DMA_SZRQn,
    output logic [31:0] A,
    output logic [31:0] D_O,
    output logic [3:0]  BEn,
    output logic        DAn,
    output logic        MRQn,
    output logic        RW,
    output logic        BCYSTn,
    input  logic [31:0] D_I,
    input  logic        READYn,
    input  logic        SZRQn,
    output logic        OWNER
);

    localparam logic [15:0] MaxHoldM1 = 16'(MAX_HOLD - 1);
    localparam logic [15:0] RearmInit = 16'(REARM);

    typedef enum logic [2:0] {
        StCpu,
        StHoldReq,
        StDma,
        StRelease,
        StReturn
    } state_e;

    state_e      state_q, state_d;
    logic        hldrqn_q, hldrqn_d;
    logic        gnt_q, gnt_d;
    logic        owner_q, owner_d;
    logic        busy_q, busy_d;
    logic [15:0] tenure_q, tenure_d;
    logic [15:0] rearm_q, rearm_d;

    logic        suppress;
    logic        bus_done;
    logic        bus_idle;

    // A DMA start strobe after the grant has been withdrawn must not reach the bus; the whole
    // bus is parked at its idle value for that cycle.
    assign suppress = owner_q & ~gnt_q & ~DMA_BCYSTn;

    always_comb begin
        A      = CPU_A;
        D_O    = CPU_DO;
        BEn    = CPU_BEn;
        DAn    = CPU_DAn;
        MRQn   = CPU_MRQn;
        RW     = CPU_RW;
        BCYSTn = CPU_BCYSTn;
        if (owner_q) begin
            if (suppress) begin
                A      = 32'h0;
                D_O    = 32'h0;
                BEn    = 4'hF;
                DAn    = 1'b1;
                MRQn   = 1'b1;
                RW     = 1'b1;
                BCYSTn = 1'b1;
            end else begin
                A      = DMA_A;
                D_O    = DMA_DO;
                BEn    = DMA_BEn;
                DAn    = DMA_DAn;
                MRQn   = DMA_MRQn;
                RW     = DMA_RW;
                BCYSTn = DMA_BCYSTn;
            end
        end
    end

    // Responses go only to the current owner; read data is broadcast.
    assign CPU_DI     = D_I;
    assign DMA_DI     = D_I;
    assign CPU_READYn = owner_q ? 1'b1 : READYn;
    assign CPU_SZRQn  = owner_q ? 1'b1 : SZRQn;
    assign DMA_READYn = owner_q ? READYn : 1'b1;
    assign DMA_SZRQn  = owner_q ? SZRQn : 1'b1;

    assign CPU_HLDRQn = hldrqn_q;
    assign DMA_GNT    = gnt_q;
    assign OWNER      = owner_q;

    assign bus_done = ~DAn & ~READYn;
    assign bus_idle = ~busy_q & BCYSTn;

    always_comb begin
        state_d  = state_q;
        hldrqn_d = hldrqn_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        busy_d   = busy_q;
        tenure_d = tenure_q;
        rearm_d  = rearm_q;
        if (CE) begin
            // Completion wins so a zero-wait cycle does not leave busy stuck high.
            if (bus_done) begin
                busy_d = 1'b0;
            end else if (!BCYSTn) begin
                busy_d = 1'b1;
            end

            unique case (state_q)
                StCpu: begin
                    if (rearm_q != 16'd0) begin
                        rearm_d = rearm_q - 16'd1;
                    end else if (DMA_REQ) begin
                        state_d  = StHoldReq;
                        hldrqn_d = 1'b0;
                    end
                end
                StHoldReq: begin
                    // A withdrawn request is not granted even if the CPU acknowledges now.
                    if (!DMA_REQ) begin
                        state_d  = StReturn;
                        hldrqn_d = 1'b1;
                    end else if (!CPU_HLDAKn) begin
                        state_d  = StDma;
                        gnt_d    = 1'b1;
                        owner_d  = 1'b1;
                        tenure_d = 16'd0;
                    end
                end
                StDma: begin
                    tenure_d = tenure_q + 16'd1;
                    if (!DMA_REQ || tenure_q == MaxHoldM1) begin
                        state_d = StRelease;
                        gnt_d   = 1'b0;
                    end
                end
                StRelease: begin
                    if (bus_idle) begin
                        state_d  = StReturn;
                        hldrqn_d = 1'b1;
                        owner_d  = 1'b0;
                    end
                end
                StReturn: begin
                    if (CPU_HLDAKn) begin
                        state_d = StCpu;
                        rearm_d = RearmInit;
                    end
                end
                default: begin
                    state_d  = StCpu;
                    hldrqn_d = 1'b1;
                    gnt_d    = 1'b0;
                    owner_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q  <= StCpu;
            hldrqn_q <= 1'b1;
            gnt_q    <= 1'b0;
            owner_q  <= 1'b0;
            busy_q   <= 1'b0;
            tenure_q <= 16'd0;
            rearm_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            hldrqn_q <= hldrqn_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
            tenure_q <= tenure_d;
            rearm_q  <= rearm_d;
        end
    end

endmodule

// File: tb/tb_v810_bus_arb.sv
// Randomized scoreboard bench for v810_bus_arb. A behavioural model of the arbitration rules
// predicts every cycle's outputs; the driver pushes predictions, a monitor pops and compares.
module tb_v810_bus_arb;

    localparam int MAX_HOLD = 8;
    localparam int REARM    = 4;

    localparam int PCpu = 0;
    localparam int PHreq = 1;
    localparam int PDma = 2;
    localparam int PRel = 3;
    localparam int PRet = 4;

    logic        CLK = 1'b0;
    logic        RES, CE;
    logic [31:0] CPU_A, CPU_DO, DMA_A, DMA_DO, D_I;
    logic [3:0]  CPU_BEn, DMA_BEn;
    logic        CPU_DAn, CPU_MRQn, CPU_RW, CPU_BCYSTn, CPU_HLDAKn;
    logic        DMA_DAn, DMA_MRQn, DMA_RW, DMA_BCYSTn, DMA_REQ;
    logic        READYn, SZRQn;
    logic [31:0] CPU_DI, DMA_DI, A, D_O;
    logic [3:0]  BEn;
    logic        CPU_READYn, CPU_SZRQn, CPU_HLDRQn, DMA_GNT, DMA_READYn, DMA_SZRQn;
    logic        DAn, MRQn, RW, BCYSTn, OWNER;

    always #5 CLK = ~CLK;

    v810_bus_arb #(.MAX_HOLD(MAX_HOLD), .REARM(REARM)) dut (
        .CLK(CLK), .RES(RES), .CE(CE),
        .CPU_A(CPU_A), .CPU_DO(CPU_DO), .CPU_BEn(CPU_BEn), .CPU_DAn(CPU_DAn),
        .CPU_MRQn(CPU_MRQn), .CPU_RW(CPU_RW), .CPU_BCYSTn(CPU_BCYSTn),
        .CPU_DI(CPU_DI), .CPU_READYn(CPU_READYn), .CPU_SZRQn(CPU_SZRQn),
        .CPU_HLDRQn(CPU_HLDRQn), .CPU_HLDAKn(CPU_HLDAKn),
        .DMA_REQ(DMA_REQ), .DMA_GNT(DMA_GNT),
        .DMA_A(DMA_A), .DMA_DO(DMA_DO), .DMA_BEn(DMA_BEn), .DMA_DAn(DMA_DAn),
        .DMA_MRQn(DMA_MRQn), .DMA_RW(DMA_RW), .DMA_BCYSTn(DMA_BCYSTn),
        .DMA_DI(DMA_DI), .DMA_READYn(DMA_READYn), .DMA_SZRQn(DMA_SZRQn),
        .A(A), .D_O(D_O), .BEn(BEn), .DAn(DAn), .MRQn(MRQn), .RW(RW), .BCYSTn(BCYSTn),
        .D_I(D_I), .READYn(READYn), .SZRQn(SZRQn), .OWNER(OWNER)
    );

    typedef struct {
        bit          chk;
        int          cyc;
        logic [2:0]  ctl;   // {OWNER, DMA_GNT, CPU_HLDRQn}
        logic [71:0] bus;   // {A, D_O, BEn, DAn, MRQn, RW, BCYSTn}
        logic [67:0] rsp;   // {CPU_DI, DMA_DI, CPU_READYn, CPU_SZRQn, DMA_READYn, DMA_SZRQn}
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   running = 1'b0;
    bit   auto_hold = 1'b0;
    bit   lazy_hold = 1'b0;

    // Reference model: phase of the handoff plus elapsed-cycle counters.
    int m_st = -1;      // -1 until the first reset
    int m_since = 0;    // CE cycles spent with the CPU since it got the bus back
    int m_granted = 0;  // CE cycles the grant has been up
    bit m_busy = 1'b0;

    function automatic bit m_owner();
        return (m_st == PDma) || (m_st == PRel);
    endfunction

    function automatic bit m_hrq();
        return !((m_st == PHreq) || (m_st == PDma) || (m_st == PRel));
    endfunction

    task automatic cpu_idle();
        CPU_A = 32'h0; CPU_DO = 32'h0; CPU_BEn = 4'hF;
        CPU_DAn = 1'b1; CPU_MRQn = 1'b1; CPU_RW = 1'b1; CPU_BCYSTn = 1'b1;
    endtask

    task automatic dma_idle();
        DMA_A = 32'h0; DMA_DO = 32'h0; DMA_BEn = 4'hF;
        DMA_DAn = 1'b1; DMA_MRQn = 1'b1; DMA_RW = 1'b1; DMA_BCYSTn = 1'b1;
    endtask

    // Predict this cycle's outputs, advance the model over the coming edge, wait a cycle.
    task automatic tick();
        exp_t e;
        bit owner, gnt, b_bcystn, b_dan, idle, done;
        if (auto_hold && (!lazy_hold || ($urandom % 3 == 0))) CPU_HLDAKn = m_hrq();
        owner = m_owner();
        gnt = (m_st == PDma);
        e.chk = (m_st >= 0);
        e.cyc = cyc;
        e.ctl = {owner, gnt, m_hrq()};
        if (!owner)
            e.bus = {CPU_A, CPU_DO, CPU_BEn, CPU_DAn, CPU_MRQn, CPU_RW, CPU_BCYSTn};
        else if (!gnt && !DMA_BCYSTn)
            e.bus = {32'h0, 32'h0, 4'hF, 4'b1111};
        else
            e.bus = {DMA_A, DMA_DO, DMA_BEn, DMA_DAn, DMA_MRQn, DMA_RW, DMA_BCYSTn};
        e.rsp = {D_I, D_I, owner | READYn, owner | SZRQn, !owner | READYn, !owner | SZRQn};
        q.push_back(e);

        b_bcystn = e.bus[0];
        b_dan = e.bus[3];
        if (RES) begin
            m_st = PCpu; m_since = REARM; m_granted = 0; m_busy = 1'b0;
        end else if (CE && m_st >= 0) begin
            idle = !m_busy && b_bcystn;
            done = !b_dan && !READYn;
            case (m_st)
                PCpu: begin
                    if (m_since >= REARM && DMA_REQ) m_st = PHreq;
                    else if (m_since < REARM) m_since++;
                end
                PHreq: begin
                    if (!DMA_REQ) m_st = PRet;
                    else if (!CPU_HLDAKn) begin m_st = PDma; m_granted = 0; end
                end
                PDma: begin
                    m_granted++;
                    if (!DMA_REQ || m_granted == MAX_HOLD) m_st = PRel;
                end
                PRel: if (idle) m_st = PRet;
                PRet: if (CPU_HLDAKn) begin m_st = PCpu; m_since = 0; end
                default: m_st = PCpu;
            endcase
            if (done) m_busy = 1'b0;
            else if (!b_bcystn) m_busy = 1'b1;
        end
        cyc++;
        @(negedge CLK);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_phase(input int ph, input int budget, input string what);
        int k;
        k = 0;
        while (m_st != ph && k < budget) begin
            tick();
            k++;
        end
        if (m_st != ph) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_%s: phase %0d after %0d cycles, required %0d", what, m_st, k, ph);
        end
    endtask

    // Monitor: compares the DUT against the oldest prediction each cycle.
    initial begin
        exp_t e;
        logic [2:0]  g_ctl;
        logic [71:0] g_bus;
        logic [67:0] g_rsp;
        forever begin
            @(negedge CLK);
            #3;
            if (q.size() == 0) begin
                if (running) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got no prediction, required one");
                end
            end else begin
                e = q.pop_front();
                if (e.chk) begin
                    g_ctl = {OWNER, DMA_GNT, CPU_HLDRQn};
                    g_bus = {A, D_O, BEn, DAn, MRQn, RW, BCYSTn};
                    g_rsp = {CPU_DI, DMA_DI, CPU_READYn, CPU_SZRQn, DMA_READYn, DMA_SZRQn};
                    n_cmp += 3;
                    if (g_ctl !== e.ctl) begin
                        n_fail++;
                        $display("FAIL ctl cyc%0d: got %b required %b", e.cyc, g_ctl, e.ctl);
                    end
                    if (g_bus !== e.bus) begin
                        n_fail++;
                        $display("FAIL bus cyc%0d: got %h required %h", e.cyc, g_bus, e.bus);
                    end
                    if (g_rsp !== e.rsp) begin
                        n_fail++;
                        $display("FAIL rsp cyc%0d: got %h required %h", e.cyc, g_rsp, e.rsp);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gcnt;
        RES = 1'b1; CE = 1'b1; CPU_HLDAKn = 1'b1; DMA_REQ = 1'b0;
        READYn = 1'b1; SZRQn = 1'b1; D_I = 32'h0;
        cpu_idle();
        dma_idle();
        @(negedge CLK);
        running = 1'b1;

        // Reset, then a CPU read passes straight through.
        ticks(3);
        RES = 1'b0;
        tick();
        CPU_A = 32'hFFF0_0000; CPU_BEn = 4'h0; CPU_MRQn = 1'b0; CPU_BCYSTn = 1'b0;
        tick();
        CPU_BCYSTn = 1'b1; CPU_DAn = 1'b0;
        tick();
        READYn = 1'b0; D_I = $urandom;
        tick();
        cpu_idle(); READYn = 1'b1;
        tick();

        // Basic handoff with a 3-cycle acknowledge delay, then a DMA write.
        DMA_REQ = 1'b1;
        ticks(3);
        CPU_HLDAKn = 1'b0;
        wait_phase(PDma, 4, "grant");
        DMA_A = 32'h0000_0010; DMA_DO = $urandom; DMA_BEn = 4'h0; DMA_RW = 1'b0;
        DMA_MRQn = 1'b0; DMA_BCYSTn = 1'b0;
        tick();
        DMA_BCYSTn = 1'b1; DMA_DAn = 1'b0; READYn = 1'b0;
        tick();
        dma_idle(); READYn = 1'b1;
        DMA_REQ = 1'b0;
        auto_hold = 1'b1;
        wait_phase(PCpu, 10, "return");
        ticks(REARM + 1);

        // Tenure limit: request held, grant must last exactly MAX_HOLD cycles.
        DMA_REQ = 1'b1;
        gcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (DMA_GNT === 1'b1) gcnt++;
            else if (gcnt > 0) break;
            tick();
        end
        n_cmp++;
        if (gcnt != MAX_HOLD) begin
            n_fail++;
            $display("FAIL tenure_len: got %0d required %0d", gcnt, MAX_HOLD);
        end
        ticks(12);  // rearm window then a fresh request cycle
        DMA_REQ = 1'b0;
        wait_phase(PCpu, 20, "tenure_return");
        ticks(REARM + 1);

        // Release while a DMA read sits in 3 wait states.
        DMA_REQ = 1'b1;
        wait_phase(PDma, 10, "grant2");
        DMA_A = $urandom; DMA_BEn = 4'h0; DMA_MRQn = 1'b0; DMA_BCYSTn = 1'b0;
        tick();
        DMA_BCYSTn = 1'b1; DMA_DAn = 1'b0; DMA_REQ = 1'b0;
        ticks(3);
        READYn = 1'b0; D_I = $urandom;
        tick();
        READYn = 1'b1; dma_idle();
        ticks(3);
        wait_phase(PCpu, 10, "release_return");
        ticks(REARM + 1);

        // Illegal start right after the grant drops.
        DMA_REQ = 1'b1;
        wait_phase(PDma, 10, "grant3");
        DMA_REQ = 1'b0;
        tick();
        DMA_BCYSTn = 1'b0; DMA_A = 32'hDEAD_BEEF;
        tick();
        dma_idle();
        ticks(4);

        // Reset in the middle of a tenure.
        wait_phase(PCpu, 10, "pre_reset");
        ticks(REARM + 1);
        DMA_REQ = 1'b1;
        wait_phase(PDma, 10, "grant4");
        tick();
        RES = 1'b1;
        tick();
        RES = 1'b0; DMA_REQ = 1'b0;
        ticks(3);

        // Random traffic with CE gating, lazy acknowledges and rare resets.
        lazy_hold = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            CE = ($urandom % 4) != 0;
            RES = ($urandom % 400) == 0;
            if ($urandom % 12 == 0) DMA_REQ = ~DMA_REQ;
            CPU_A = $urandom; CPU_DO = $urandom; CPU_BEn = 4'($urandom);
            CPU_DAn = 1'($urandom); CPU_MRQn = 1'($urandom); CPU_RW = 1'($urandom);
            CPU_BCYSTn = ($urandom % 3) != 0;
            DMA_A = $urandom; DMA_DO = $urandom; DMA_BEn = 4'($urandom);
            DMA_DAn = 1'($urandom); DMA_MRQn = 1'($urandom); DMA_RW = 1'($urandom);
            DMA_BCYSTn = ($urandom % 3) != 0;
            READYn = ($urandom % 3) == 0;
            SZRQn = 1'($urandom);
            D_I = $urandom;
            tick();
        end

        running = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
